uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive half of the SoC debug UART: deserializes 8N1 asynchronous frames from the `rx` pin into a small first-word-fall-through FIFO that the CPU drains over the peripheral bus. It complements the transmit path whose output the simulation environment captures to the debug log. In system simulation the bench drives `rx` to inject console input into running software.

## Interface
- `CLK_DIV`, 434: clock cycles per bit, ≥ 4. 434 gives 57600 baud at 25 MHz.
- `FIFO_DEPTH`, 8: receive FIFO entries, power of two, ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `rd_en`  in  1  pop the FIFO head; ignored when empty.
- `err_clr`  in  1  clears `overrun` and `frame_err`.
- `rd_data`  out  8  FIFO head byte, valid while `rx_valid` = 1.
- `rx_valid`  out  1  FIFO not empty.
- `count`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit sampled low (or bad parity when enabled).
- `irq`  out  1  registered `rx_valid | overrun | frame_err`.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. All logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, PARITY (present only when compiled in), STOP.
- IDLE: on `rxs` = 0, load the bit counter with CLK_DIV/2 − 1 and go to START.
- START: when the counter reaches 0, sample `rxs`.
  - 0: reload CLK_DIV − 1, clear the bit index, go to DATA.
  - 1: glitch; return to IDLE with no flags set.
- DATA: each counter expiry shifts `rxs` into bit[index], LSB first, then reloads CLK_DIV − 1. After bit 7, go to PARITY or STOP.
- STOP: on counter expiry, sample `rxs`.
  - 1: push the byte.
  - 0: set `frame_err` and discard the byte.
  - Either way, return to IDLE in the same cycle.
- Push while full: the byte is dropped and `overrun` is set. The exception is a simultaneous pop in the same cycle; then the push is accepted and `overrun` is not set.
- Push and pop on an empty FIFO in the same cycle: `rd_en` is ignored, the push occurs, `count` = 1.
- FIFO pointers wrap modulo FIFO_DEPTH. `count` ranges 0..FIFO_DEPTH.
- `err_clr` has lower priority than a same-cycle set: the flag stays 1.
- Reset mid-frame aborts the frame with no flag and no push.

## Timing
- All outputs reset to 0, except that `rd_data` resets to 0x00 (FIFO storage is not reset).
- `rx` falling edge to FSM leaving IDLE: 3 `clk` edges (2 synchronizer stages plus detect).
- Let t0 be the cycle the FSM enters START.
  - Stop sample occurs at t0 + CLK_DIV/2 + 9·CLK_DIV (add CLK_DIV with parity).
  - `rx_valid`, `count` and `rd_data` update at the next edge, t0 + CLK_DIV/2 + 9·CLK_DIV + 1.
- A pop updates `rd_data` and `count` on the edge after `rd_en` is sampled. `rd_data` then shows the next entry, or holds the stale value when empty.
- `irq` lags its sources by 1 cycle.
- A new start bit is accepted in the cycle after STOP; back-to-back frames with one stop bit are supported.
- Tolerated baud mismatch: ±3 % total.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present and the frame is 8E1.
  - The parity bit is sampled one CLK_DIV after bit 7.
  - Even parity is checked; on mismatch, `frame_err` is set and the byte is discarded at STOP.
- Undefined: frames are 8N1, the PARITY state and its logic are absent, and the stop bit directly follows bit 7.

## Test plan
All scenarios use CLK_DIV = 16 and FIFO_DEPTH = 4.
- Single frame 0xA5 on `rx` -> `rx_valid` = 1 and `rd_data` = 0xA5, 153 cycles after START entry; `count` = 1; flags 0.
- Five back-to-back frames 0x01..0x05 with no reads -> `count` = 4, `overrun` = 1; reads return 0x01..0x04, then `rx_valid` = 0.
- Frame 0x3C with stop bit held low -> `frame_err` = 1, `count` = 0. `err_clr` pulse -> `frame_err` = 0 next cycle.
- Low pulse of 6 cycles on idle `rx` -> FSM back in IDLE, `count` = 0, no flags.
- FIFO full, `rd_en` asserted in the stop-sample cycle of a fifth frame 0x55 -> `count` stays 4, `overrun` = 0, and 0x55 is the last entry.
- Reset asserted during bit 3 of a frame, released 5 cycles later -> all outputs 0 and the next frame 0x7E is received correctly.
- With `UART_RX_PARITY_EN`: frame 0x07 sent with parity bit 0 -> `frame_err` = 1 and no push. With parity bit 1 -> `rd_data` = 0x07.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive half of the SoC debug UART.
// Deserializes asynchronous frames from rx into a first-word-fall-through FIFO
// that the CPU drains through rd_en / rd_data.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with an even-parity
// check; leave it undefined for plain 8N1 frames.

module uart_rx_fifo #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    input  logic                        rd_en,
    input  logic                        err_clr,
    output logic [7:0]                  rd_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overrun,
    output logic                        frame_err,
    output logic                        irq
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // Synchronizer
    logic rx_meta;
    logic rxs;

    // Receiver FSM
    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          push;
    logic [7:0]    push_data;
    logic          stop_ok;

    // FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // Two-stage synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: non-blocking so rxs takes the old rx_meta, giving two real stages.
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign stop_ok = rxs && !par_err;
`else
    assign stop_ok = rxs;
`endif

    // Frame FSM: mid-bit sampling, byte assembly, frame_err flag and push strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push      <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            // A set later in this block overrides the clear in the same cycle.
            if (err_clr) frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        bit_cnt <= HALF_LOAD;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == '0) begin
                        if (!rxs) begin
                            bit_cnt <= BIT_LOAD;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        shift[bit_idx] <= rxs;
                        bit_cnt        <= BIT_LOAD;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == '0) begin
                        par_err <= (rxs != ^shift);
                        bit_cnt <= BIT_LOAD;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (bit_cnt == '0) begin
                        state <= IDLE;
                        if (stop_ok) begin
                            push      <= 1'b1;
                            push_data <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO accept/drop decisions; a pop on a full FIFO makes room for a same-cycle push
    always_comb begin
        // NOTE: every signal is assigned on every path, so no latch can be inferred.
        do_pop  = rd_en && (count != '0);
        do_push = push && ((count != DEPTH_CNT) || do_pop);
        drop    = push && (count == DEPTH_CNT) && !do_pop;
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately left unreset; occupancy tracking makes stale entries invisible.
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy, registered head byte and overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;

            if (do_push && !do_pop)      count <= count + ONE_CNT;
            else if (do_pop && !do_push) count <= count - ONE_CNT;

            // Head tracks the oldest entry; it holds its stale value once the FIFO drains.
            if (do_push && ((count == '0) || (do_pop && count == ONE_CNT)))
                rd_data <= push_data;
            else if (do_pop && count > ONE_CNT)
                rd_data <= mem[rd_ptr + PTR_ONE];

            if (drop)         overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

    assign rx_valid = (count != '0);

    // Interrupt line, registered one cycle behind its sources
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= rx_valid | overrun | frame_err;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo with CLK_DIV = 16 and FIFO_DEPTH = 4.
// Frames are driven bit by bit on rx; a byte queue plus two flag bits model
// what the receiver should hold after each frame and each read.

module tb_uart_rx_fifo;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 11;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 10;
`endif
    // Edges from the rx falling edge until the received byte shows at the FIFO:
    // 3 to leave IDLE, half a bit to the start sample, NB-1 bits to the stop
    // sample, one more edge for the push.
    localparam int LAT = 3 + CLK_DIV / 2 + (NB - 1) * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] count;
    logic       overrun;
    logic       frame_err;
    logic       irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       ovr = 1'b0;
    logic       ferr = 1'b0;

    uart_rx_fifo #(
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx(rx),
        .rd_en(rd_en),
        .err_clr(err_clr),
        .rd_data(rd_data),
        .rx_valid(rx_valid),
        .count(count),
        .overrun(overrun),
        .frame_err(frame_err),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        rd_en = 1'b0;
        err_clr = 1'b0;
        repeat (n) tick();
    endtask

    // Send one frame; pulse rd_en / err_clr in the given cycle (-1 = never).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_bit, input int pop_cyc,
                              input int clr_cyc, input bit chk_lat);
        logic [NB-1:0] bits;
        logic          good;
        logic [6:0]    exp_st;
        logic          nonempty;
        bits = '0;
        bits[8:1] = data;
        if (PAR) bits[NB-2] = par_bit;
        bits[NB-1] = stop_bit;
        good = stop_bit && (!PAR || (par_bit == ^data));
        for (int c = 0; c < NB * CLK_DIV; c++) begin
            rx = bits[c / CLK_DIV];
            rd_en = (c == pop_cyc);
            err_clr = (c == clr_cyc);
            tick();
            if (chk_lat && (c + 1 == LAT - 1)) begin
                checks++;
                if (rx_valid !== 1'b0)
                    $display("FAIL latency_early: rx_valid=%b one edge before push, expected 0", rx_valid);
            end
            if (chk_lat && (c + 1 == LAT)) begin
                checks++;
                if ({rx_valid, rd_data, irq} !== {1'b1, data, 1'b0}) begin
                    errors++;
                    $display("FAIL latency_push: valid=%b data=%h irq=%b, expected valid=1 data=%h irq=0",
                             rx_valid, rd_data, irq, data);
                end
            end
            if (chk_lat && (c + 1 == LAT + 1)) begin
                checks++;
                if (irq !== 1'b1) begin
                    errors++;
                    $display("FAIL irq_lag: irq=%b, expected 1", irq);
                end
            end
        end
        rx = 1'b1;
        rd_en = 1'b0;
        err_clr = 1'b0;
        // Reference model: a pop is taken before the push, clears before sets.
        if (pop_cyc >= 0 && q.size() != 0) void'(q.pop_front());
        if (clr_cyc >= 0) begin
            ovr = 1'b0;
            ferr = 1'b0;
        end
        if (!good) ferr = 1'b1;
        else if (q.size() < FIFO_DEPTH) q.push_back(data);
        else ovr = 1'b1;
        nonempty = (q.size() != 0);
        exp_st = {nonempty, 3'(q.size()), ovr, ferr, nonempty | ovr | ferr};
        checks++;
        if ({rx_valid, count, overrun, frame_err, irq} !== exp_st) begin
            errors++;
            $display("FAIL frame_status(%h): valid/count/ovr/ferr/irq=%b, expected %b",
                     data, {rx_valid, count, overrun, frame_err, irq}, exp_st);
        end
        if (nonempty) begin
            checks++;
            if (rd_data !== q[0]) begin
                errors++;
                $display("FAIL frame_head(%h): rd_data=%h, expected %h", data, rd_data, q[0]);
            end
        end
    endtask

    // Pop one byte and check both the head before and the state after.
    task automatic read_one();
        logic [7:0]  head;
        logic [11:0] exp_v;
        head = q[0];
        checks++;
        if ({rx_valid, rd_data} !== {1'b1, head}) begin
            errors++;
            $display("FAIL read_head: valid=%b data=%h, expected valid=1 data=%h", rx_valid, rd_data, head);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        void'(q.pop_front());
        if (q.size() != 0) exp_v = {1'b1, q[0], 3'(q.size())};
        else               exp_v = {1'b0, head, 3'd0};
        checks++;
        if ({rx_valid, rd_data, count} !== exp_v) begin
            errors++;
            $display("FAIL read_after: valid/data/count=%h, expected %h", {rx_valid, rd_data, count}, exp_v);
        end
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        ovr = 1'b0;
        ferr = 1'b0;
        checks++;
        if ({overrun, frame_err} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr: overrun=%b frame_err=%b, expected 0 0", overrun, frame_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rd_data, rx_valid, count, overrun, frame_err, irq} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%h, expected 0", {rd_data, rx_valid, count, overrun, frame_err, irq});
        end
        reset = 1'b0;
        idle(4);
        checks++;
        if ({rd_data, rx_valid, count, overrun, frame_err, irq} !== '0) begin
            errors++;
            $display("FAIL reset_release: outputs=%h, expected 0", {rd_data, rx_valid, count, overrun, frame_err, irq});
        end
    endtask

    task automatic test_single_frame();
        send_frame(8'hA5, 1'b1, ^8'hA5, -1, -1, 1'b1);
        checks++;
        if ({count, overrun, frame_err} !== {3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_frame: count=%0d ovr=%b ferr=%b, expected 1 0 0", count, overrun, frame_err);
        end
        read_one();
        idle(4);
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, ^b, -1, -1, 1'b0);
        end
        checks++;
        if ({count, overrun} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL back_to_back: count=%0d overrun=%b, expected 4 1", count, overrun);
        end
        while (q.size() != 0) read_one();
        clear_errors();
        idle(4);
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        send_frame(8'h3C, 1'b0, ^8'h3C, -1, -1, 1'b0);
        idle(2 * CLK_DIV);
        checks++;
        if ({frame_err, count} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL stop_low: frame_err=%b count=%0d, expected 1 0", frame_err, count);
        end
        clear_errors();
        // err_clr in the stop-sample cycle of a bad frame: the set wins.
        b = 8'($urandom);
        send_frame(b, 1'b0, ^b, -1, LAT - 2, 1'b0);
        idle(2 * CLK_DIV);
        clear_errors();
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        rx = 1'b0;
        repeat (6) tick();
        idle(3 * CLK_DIV);
        checks++;
        if ({rx_valid, count, overrun, frame_err, irq} !== '0) begin
            errors++;
            $display("FAIL glitch: valid/count/ovr/ferr/irq=%b, expected 0", {rx_valid, count, overrun, frame_err, irq});
        end
        b = 8'($urandom);
        send_frame(b, 1'b1, ^b, -1, -1, 1'b1);
        read_one();
        idle(4);
    endtask

    task automatic test_full_pop();
        logic [7:0] b;
        // Pop and push together on an empty FIFO: the pop is ignored.
        b = 8'($urandom);
        send_frame(b, 1'b1, ^b, LAT - 1, -1, 1'b0);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL empty_push_pop: count=%0d, expected 1", count);
        end
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, ^b, -1, -1, 1'b0);
        end
        send_frame(8'h55, 1'b1, ^8'h55, LAT - 1, -1, 1'b0);
        checks++;
        if ({count, overrun} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d overrun=%b, expected 4 0", count, overrun);
        end
        while (q.size() != 0) read_one();
        checks++;
        if (rd_data !== 8'h55) begin
            errors++;
            $display("FAIL full_last: rd_data=%h, expected 55", rd_data);
        end
        idle(4);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic [7:0] p;
        b = 8'($urandom) | 8'h01;
        send_frame(b, 1'b1, ^b, -1, -1, 1'b0);
        p = 8'($urandom);
        for (int c = 0; c < 4 * CLK_DIV + 6; c++) begin
            rx = (c < CLK_DIV) ? 1'b0 : p[c / CLK_DIV - 1];
            tick();
        end
        reset = 1'b1;
        rx = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        q.delete();
        ovr = 1'b0;
        ferr = 1'b0;
        idle(2 * CLK_DIV);
        checks++;
        if ({rd_data, rx_valid, count, overrun, frame_err, irq} !== '0) begin
            errors++;
            $display("FAIL reset_mid: outputs=%h, expected 0", {rd_data, rx_valid, count, overrun, frame_err, irq});
        end
        send_frame(8'h7E, 1'b1, ^8'h7E, -1, -1, 1'b1);
        read_one();
        idle(4);
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic       good;
        int         n;
        for (int i = 0; i < 14; i++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, good, ^b, -1, -1, 1'b0);
            if (!good) idle(2 * CLK_DIV);
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                if (q.size() != 0) read_one();
            end
            idle($urandom_range(0, 20));
        end
        while (q.size() != 0) read_one();
        clear_errors();
        idle(4);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b1, 1'b0, -1, -1, 1'b0);
        checks++;
        if ({frame_err, count} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL parity_bad: frame_err=%b count=%0d, expected 1 0", frame_err, count);
        end
        idle(CLK_DIV);
        clear_errors();
        send_frame(8'h07, 1'b1, 1'b1, -1, -1, 1'b1);
        checks++;
        if (rd_data !== 8'h07) begin
            errors++;
            $display("FAIL parity_good: rd_data=%h, expected 07", rd_data);
        end
        read_one();
        idle(4);
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        rd_en = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_full_pop();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
